// File: rtl/present_key_schedule_if.sv
// Round-key handshake bundle between the PRESENT key schedule and its consumer.
// The master side is the round datapath; the slave side is the key schedule.
interface present_key_schedule_if #(
    parameter int KEY_WIDTH = 80
);
    logic [KEY_WIDTH-1:0] keyIn;
    logic                 keyLoad;
    logic                 roundKeyAdv;
    logic [63:0]          roundKey;
    logic                 roundKeyValid;
    logic [5:0]           roundIdx;
    logic                 lastKey;
    logic                 busy;

    modport master (
        output keyIn, keyLoad, roundKeyAdv,
        input  roundKey, roundKeyValid, roundIdx, lastKey, busy
    );

    modport slave (
        input  keyIn, keyLoad, roundKeyAdv,
        output roundKey, roundKeyValid, roundIdx, lastKey, busy
    );
endinterface

// File: rtl/present_key_schedule.sv
// Iterative PRESENT key schedule (80- or 128-bit user key).
// Produces round keys K1..K32 one per accepted advance; keyLoad restarts at any time.
// All outputs are decoded from registers only.
module present_key_schedule #(
    parameter int KEY_WIDTH = 80,
    parameter int NUM_KEYS  = 32
) (
    input logic                   clk,
    input logic                   rstN,
    present_key_schedule_if.slave ks
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic [KEY_WIDTH-1:0] keyReg;
    logic [KEY_WIDTH-1:0] keyNext;
    logic [KEY_WIDTH-1:0] keyRotated;
    logic [KEY_WIDTH-1:0] keyUpdated;
    logic [5:0]           idxReg;
    logic [5:0]           idxNext;

    // PRESENT 4-bit S-box
    function automatic logic [3:0] PresentSBoxFun(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Rotate left by 61: the low KEY_WIDTH-61 bits move to the top
    assign keyRotated = {keyReg[KEY_WIDTH-62:0], keyReg[KEY_WIDTH-1:KEY_WIDTH-61]};

    if (KEY_WIDTH == 80) begin : genK80
        // 80-bit update: one S-box on the top nibble, counter into bits 19:15
        always_comb begin
            keyUpdated        = keyRotated;
            keyUpdated[79:76] = PresentSBoxFun(keyRotated[79:76]);
            keyUpdated[19:15] = keyRotated[19:15] ^ idxReg[4:0];
        end
    end else if (KEY_WIDTH == 128) begin : genK128
        // 128-bit update: S-boxes on the two top nibbles, counter into bits 66:62
        always_comb begin
            keyUpdated          = keyRotated;
            keyUpdated[127:124] = PresentSBoxFun(keyRotated[127:124]);
            keyUpdated[123:120] = PresentSBoxFun(keyRotated[123:120]);
            keyUpdated[66:62]   = keyRotated[66:62] ^ idxReg[4:0];
        end
    end else begin : genBadWidth
        $fatal(1, "present_key_schedule: KEY_WIDTH must be 80 or 128");
    end

    // State, key and round-index registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= IDLE;
            keyReg <= '0;
            idxReg <= '0;
        end else begin
            state  <= stateNext;
            keyReg <= keyNext;
            idxReg <= idxNext;
        end
    end

    // Next-state decode: keyLoad overrides any advance; the final advance wipes the key
    always_comb begin
        stateNext = state;
        keyNext   = keyReg;
        idxNext   = idxReg;
        if (ks.keyLoad) begin
            stateNext = ACTIVE;
            keyNext   = ks.keyIn;
            idxNext   = 6'd1;
        end else if (state == ACTIVE && ks.roundKeyAdv) begin
            if (idxReg == 6'(NUM_KEYS)) begin
                stateNext = IDLE;
                keyNext   = '0;
                idxNext   = '0;
            end else begin
                keyNext = keyUpdated;
                idxNext = idxReg + 6'd1;
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        ks.roundKey      = keyReg[KEY_WIDTH-1 -: 64];
        ks.roundKeyValid = (state == ACTIVE);
        ks.roundIdx      = idxReg;
        ks.lastKey       = (state == ACTIVE) && (idxReg == 6'(NUM_KEYS));
        ks.busy          = (state == ACTIVE);
    end

endmodule

// File: tb/tb_present_key_schedule.sv
// Directed testbench for present_key_schedule (80-bit and 128-bit instances).
module tb_present_key_schedule;

    logic clk = 1'b0;
    logic rstN;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    present_key_schedule_if #(.KEY_WIDTH(80))  ifA ();
    present_key_schedule_if #(.KEY_WIDTH(128)) ifB ();

    present_key_schedule #(.KEY_WIDTH(80), .NUM_KEYS(32)) dutA (
        .clk  (clk),
        .rstN (rstN),
        .ks   (ifA)
    );

    present_key_schedule #(.KEY_WIDTH(128), .NUM_KEYS(32)) dutB (
        .clk  (clk),
        .rstN (rstN),
        .ks   (ifB)
    );

    logic [3:0] sboxTbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    typedef struct {
        logic [79:0] key;
        int unsigned advs;
        logic [63:0] expKey;
        logic [5:0]  expIdx;
    } vecT;

    vecT vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference key update, bit-by-bit rotation
    function automatic logic [79:0] nextKey80(input logic [79:0] k, input int unsigned r);
        logic [79:0] t;
        logic [4:0]  rc;
        rc = r[4:0];
        for (int unsigned i = 0; i < 80; i++) t[(i + 61) % 80] = k[i];
        t[79:76] = sboxTbl[t[79:76]];
        for (int unsigned i = 0; i < 5; i++) t[15 + i] = t[15 + i] ^ rc[i];
        return t;
    endfunction

    function automatic logic [127:0] nextKey128(input logic [127:0] k, input int unsigned r);
        logic [127:0] t;
        logic [4:0]   rc;
        rc = r[4:0];
        for (int unsigned i = 0; i < 128; i++) t[(i + 61) % 128] = k[i];
        t[127:124] = sboxTbl[t[127:124]];
        t[123:120] = sboxTbl[t[123:120]];
        for (int unsigned i = 0; i < 5; i++) t[62 + i] = t[62 + i] ^ rc[i];
        return t;
    endfunction

    function automatic logic [63:0] sLayer(input logic [63:0] s);
        logic [63:0] o;
        for (int unsigned n = 0; n < 16; n++) o[4*n +: 4] = sboxTbl[s[4*n +: 4]];
        return o;
    endfunction

    function automatic logic [63:0] pLayer(input logic [63:0] s);
        logic [63:0] o;
        for (int unsigned i = 0; i < 63; i++) o[(16 * i) % 63] = s[i];
        o[63] = s[63];
        return o;
    endfunction

    task automatic load80(input logic [79:0] key);
        ifA.keyIn   = key;
        ifA.keyLoad = 1'b1;
        tick();
        ifA.keyLoad = 1'b0;
    endtask

    task automatic advance80(input int unsigned n);
        ifA.roundKeyAdv = 1'b1;
        repeat (n) tick();
        ifA.roundKeyAdv = 1'b0;
    endtask

    task automatic checkIdleA(input string tag);
        check({tag, ".key"},   ifA.roundKey,      '0);
        check({tag, ".valid"}, ifA.roundKeyValid, '0);
        check({tag, ".idx"},   ifA.roundIdx,      '0);
        check({tag, ".last"},  ifA.lastKey,       '0);
        check({tag, ".busy"},  ifA.busy,          '0);
    endtask

    initial begin
        logic [79:0]  mk;
        logic [127:0] mkB;
        logic [63:0]  st;
        int unsigned  r;
        int unsigned  cyc;
        logic         adv;

        vecs[0] = '{80'h0, 0, 64'h0000000000000000, 6'd1};
        vecs[1] = '{80'h0, 1, 64'hC000000000000000, 6'd2};
        vecs[2] = '{80'h0, 2, 64'h5000180000000001, 6'd3};
        vecs[3] = '{80'hFFFFFFFFFFFFFFFFFFFF, 1, 64'h2FFFFFFFFFFFFFFF, 6'd2};
        vecs[4] = '{80'h0123456789ABCDEF4567, 0, 64'h0123456789ABCDEF, 6'd1};

        rstN = 1'b0;
        ifA.keyIn = '0; ifA.keyLoad = 1'b0; ifA.roundKeyAdv = 1'b0;
        ifB.keyIn = '0; ifB.keyLoad = 1'b0; ifB.roundKeyAdv = 1'b0;
        #12;
        checkIdleA("reset");
        check("reset.busyB", ifB.busy, '0);
        rstN = 1'b1;
        tick();

        // Advance while idle is ignored
        advance80(3);
        checkIdleA("idleAdv");

        // Vector table
        foreach (vecs[v]) begin
            load80(vecs[v].key);
            advance80(vecs[v].advs);
            check($sformatf("vec%0d.key", v),   ifA.roundKey,      vecs[v].expKey);
            check($sformatf("vec%0d.idx", v),   ifA.roundIdx,      vecs[v].expIdx);
            check($sformatf("vec%0d.valid", v), ifA.roundKeyValid, 1'b1);
        end

        // Full all-ones stream with advance held high
        mk = '1;
        load80(mk);
        ifA.roundKeyAdv = 1'b1;
        for (int unsigned k = 1; k <= 32; k++) begin
            check($sformatf("stream.key%0d", k),  ifA.roundKey,      mk[79:16]);
            check($sformatf("stream.idx%0d", k),  ifA.roundIdx,      6'(k));
            check($sformatf("stream.last%0d", k), ifA.lastKey,       (k == 32));
            check($sformatf("stream.val%0d", k),  ifA.roundKeyValid, 1'b1);
            tick();
            if (k < 32) mk = nextKey80(mk, k);
        end
        ifA.roundKeyAdv = 1'b0;
        checkIdleA("streamEnd");

        // keyLoad together with advance mid-schedule: load wins
        load80(80'h13579BDF02468ACE1122);
        advance80(9);
        check("restart.idx10", ifA.roundIdx, 6'd10);
        ifA.keyIn       = 80'hA5A5_0F0F_3C3C_9696_7E81;
        ifA.keyLoad     = 1'b1;
        ifA.roundKeyAdv = 1'b1;
        tick();
        ifA.keyLoad     = 1'b0;
        ifA.roundKeyAdv = 1'b0;
        check("restart.idx", ifA.roundIdx, 6'd1);
        check("restart.key", ifA.roundKey, 64'hA5A5_0F0F_3C3C_9696);
        tick();
        check("restart.hold", ifA.roundKey, 64'hA5A5_0F0F_3C3C_9696);

        // Asynchronous reset mid-schedule
        load80(80'hFEDCBA98765432100123);
        advance80(16);
        check("arst.idx17", ifA.roundIdx, 6'd17);
        #3 rstN = 1'b0;
        #1 checkIdleA("arst");
        #2 rstN = 1'b1;
        advance80(3);
        checkIdleA("arstAdv");

        // 128-bit schedule with random advance gaps
        ifB.keyIn   = '0;
        ifB.keyLoad = 1'b1;
        tick();
        ifB.keyLoad = 1'b0;
        mkB = '0;
        r   = 1;
        cyc = 0;
        while (r <= 32 && cyc < 2000) begin
            adv = 1'($urandom_range(0, 1));
            ifB.roundKeyAdv = adv;
            check($sformatf("k128.key%0d", r), ifB.roundKey, mkB[127:64]);
            check($sformatf("k128.idx%0d", r), ifB.roundIdx, 6'(r));
            tick();
            cyc++;
            if (adv) begin
                if (r < 32) mkB = nextKey128(mkB, r);
                r++;
            end
        end
        ifB.roundKeyAdv = 1'b0;
        check("k128.budget", (r > 32), 1'b1);
        check("k128.endValid", ifB.roundKeyValid, 1'b0);
        check("k128.endBusy",  ifB.busy,          1'b0);

        // Integration: full PRESENT-80 encryption of plaintext 0 under key 0
        load80('0);
        st = '0;
        ifA.roundKeyAdv = 1'b1;
        for (int unsigned k = 1; k <= 32; k++) begin
            st = st ^ ifA.roundKey;
            if (k < 32) st = pLayer(sLayer(st));
            tick();
        end
        ifA.roundKeyAdv = 1'b0;
        check("cipher80", st, 64'h5579C1387B228445);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
